// File: rtl/sm3_msg_arb.sv
// sm3_msg_arb: two-requester, message-granular round-robin arbiter feeding
// the sm3_pad_core. A grant lasts for one whole message: beats pass through
// combinationally until the last beat, then the grant is held until the pad
// core reports the last padded block. Also counts the message bytes and
// pulses done_o one cycle after padding completes.
module sm3_msg_arb #(
    parameter int INPT_DW  = 32,
    parameter int BYTE_NUM = INPT_DW / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INPT_DW-1:0]  req0_d_i,
    input  logic [BYTE_NUM-1:0] req0_vld_byte_i,
    input  logic                req0_vld_i,
    input  logic                req0_lst_i,
    output logic                req0_rdy_o,
    input  logic [INPT_DW-1:0]  req1_d_i,
    input  logic [BYTE_NUM-1:0] req1_vld_byte_i,
    input  logic                req1_vld_i,
    input  logic                req1_lst_i,
    output logic                req1_rdy_o,
    output logic [INPT_DW-1:0]  msg_inpt_d_o,
    output logic [BYTE_NUM-1:0] msg_inpt_vld_byte_o,
    output logic                msg_inpt_vld_o,
    output logic                msg_inpt_lst_o,
    input  logic                msg_inpt_rdy_i,
    input  logic                pad_otpt_lst_i,
    output logic                gnt_id_o,
    output logic                busy_o,
    output logic [60:0]         msg_byte_cnt_o,
    output logic                done_o,
    output logic                done_id_o
);

    localparam int CNT_W = 61;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER     = 2'd1,
        WAIT_PAD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;

    // Granted requester's beat, selected by the latched grant id.
    logic [INPT_DW-1:0]  sel_d;
    logic [BYTE_NUM-1:0] sel_vb;
    logic                sel_vld;
    logic                sel_lst;
    logic [CNT_W-1:0]    last_bytes;
    logic                acc;

    // Steer the granted requester onto the shared bus and count valid bytes.
    always_comb begin
        sel_d      = gnt_q ? req1_d_i        : req0_d_i;
        sel_vb     = gnt_q ? req1_vld_byte_i : req0_vld_byte_i;
        sel_vld    = gnt_q ? req1_vld_i      : req0_vld_i;
        sel_lst    = gnt_q ? req1_lst_i      : req0_lst_i;
        last_bytes = '0;
        for (int i = 0; i < BYTE_NUM; i++) begin
            last_bytes = last_bytes + CNT_W'(sel_vb[i]);
        end
    end

    // Next-state logic and pass-through outputs; everything is idle outside XFER.
    always_comb begin
        state_d             = state_q;
        ptr_d               = ptr_q;
        gnt_d               = gnt_q;
        cnt_d               = cnt_q;
        done_d              = 1'b0;
        done_id_d           = done_id_q;
        req0_rdy_o          = 1'b0;
        req1_rdy_o          = 1'b0;
        msg_inpt_d_o        = '0;
        msg_inpt_vld_byte_o = '0;
        msg_inpt_vld_o      = 1'b0;
        msg_inpt_lst_o      = 1'b0;
        acc                 = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_vld_i || req1_vld_i) begin
                    // Pointer only matters on contention; a lone requester always wins.
                    gnt_d   = (req0_vld_i && req1_vld_i) ? ptr_q : req1_vld_i;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                msg_inpt_d_o        = sel_d;
                msg_inpt_vld_byte_o = sel_vb;
                msg_inpt_vld_o      = sel_vld;
                msg_inpt_lst_o      = sel_lst;
                req0_rdy_o          = !gnt_q && msg_inpt_rdy_i;
                req1_rdy_o          =  gnt_q && msg_inpt_rdy_i;
                acc                 = sel_vld && msg_inpt_rdy_i;
                if (acc) begin
                    if (sel_lst) begin
                        cnt_d   = cnt_q + last_bytes;
                        state_d = WAIT_PAD;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(BYTE_NUM);
                    end
                end
            end
            WAIT_PAD: begin
                if (pad_otpt_lst_i) begin
                    done_d    = 1'b1;
                    done_id_d = gnt_q;
                    ptr_d     = ~gnt_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign gnt_id_o       = gnt_q;
    assign busy_o         = (state_q != IDLE);
    assign msg_byte_cnt_o = cnt_q;
    assign done_o         = done_q;
    assign done_id_o      = done_id_q;

endmodule
